// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: operand widths, carry-select block size
// and the divider state encoding.
package arith_pkg;

   localparam int DIV_WIDTH = 64;
   localparam int CSA_BLOCK = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider_64_if.sv
// Request/result bundle of the sequential divider; the requester drives the
// operands and start, the divider returns status and results.
interface seq_divider_64_if #(parameter int WIDTH = arith_pkg::DIV_WIDTH);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/block_csa_sub.sv
// WIDTH-bit subtractor a - b built as a + ~b + 1 over carry-select blocks of
// CSA_BLOCK bits; borrow_out is the inverted final carry.
module block_csa_sub
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int NBLK = WIDTH / CSA_BLOCK;
   localparam logic [CSA_BLOCK:0] ONE = {{CSA_BLOCK{1'b0}}, 1'b1};

   logic [WIDTH-1:0] b_inv;
   logic [NBLK:0]    carry;

   assign b_inv    = ~b;
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < NBLK; g++) begin : g_blk
      logic [CSA_BLOCK:0] sum0;
      logic [CSA_BLOCK:0] sum1;

      // Both carry-in cases are formed up front; the ripple only drives the muxes.
      assign sum0 = {1'b0, a[g*CSA_BLOCK +: CSA_BLOCK]} + {1'b0, b_inv[g*CSA_BLOCK +: CSA_BLOCK]};
      assign sum1 = {1'b0, a[g*CSA_BLOCK +: CSA_BLOCK]} + {1'b0, b_inv[g*CSA_BLOCK +: CSA_BLOCK]} + ONE;

      assign diff[g*CSA_BLOCK +: CSA_BLOCK] = carry[g] ? sum1[CSA_BLOCK-1:0] : sum0[CSA_BLOCK-1:0];
      assign carry[g+1]                     = carry[g] ? sum1[CSA_BLOCK]     : sum0[CSA_BLOCK];
   end

   assign borrow_out = ~carry[NBLK];

endmodule

// File: rtl/seq_divider_64.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with the
// carry-select subtractor as the trial-subtract stage.
module seq_divider_64
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   seq_divider_64_if.slave  bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   div_state_t       state;
   div_state_t       state_next;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;
   logic             dbz;

   logic             load;
   logic             load_dbz;
   logic             step;

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             fits;

   // The extra top bit is the shifted-out R MSB; when set, T exceeds any D.
   assign trial = {r, q[WIDTH-1]};
   assign fits  = trial[WIDTH] | ~borrow;

   block_csa_sub #(.WIDTH(WIDTH)) u_sub (
      .a          (trial[WIDTH-1:0]),
      .b          (d),
      .diff       (diff),
      .borrow_out (borrow)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      load_dbz   = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  load_dbz   = 1'b1;
                  state_next = DONE;
               end else begin
                  load       = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == LAST) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         r     <= '0;
         d     <= '0;
         count <= '0;
         dbz   <= 1'b0;
      end else if (load) begin
         q     <= bus.dividend;
         r     <= '0;
         d     <= bus.divisor;
         count <= '0;
         dbz   <= 1'b0;
      end else if (load_dbz) begin
         q     <= '1;
         r     <= bus.dividend;
         dbz   <= 1'b1;
      end else if (step) begin
         q     <= {q[WIDTH-2:0], fits};
         r     <= fits ? diff : trial[WIDTH-1:0];
         count <= count + CW'(1);
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = q;
   assign bus.remainder   = r;
   assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider_64.sv
// Directed bench for seq_divider_64: reset, normal divides, divide-by-zero,
// ignored start / mid-run reset, and back-to-back starts.
module tb_seq_divider_64;

   localparam int W      = 64;
   localparam int BUDGET = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seq_divider_64_if #(.WIDTH(W)) bus ();

   seq_divider_64 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   // lat = edges after the accepting edge until done is seen (BUDGET on timeout)
   task automatic wait_done(output int lat, output int busy_cycles);
      lat         = 0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && lat < BUDGET) begin
         if (bus.busy === 1'b1) busy_cycles++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", bus.quotient); end
      checks++; if (bus.remainder !== '0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
      rst = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus.busy, bus.done); end
   endtask

   task automatic test_div_by_zero();
      int busy_seen;
      busy_seen = 0;
      launch(64'd1228, 64'd0);
      if (bus.busy === 1'b1) busy_seen++;
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL dbz_done_latency got=%b exp=1 right after accepting edge", bus.done); end
      checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL dbz_quotient got=%h exp=ffffffffffffffff", bus.quotient); end
      checks++; if (bus.remainder !== 64'd1228) begin failures++; $display("FAIL dbz_remainder got=%0d exp=1228", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
      tick();
      if (bus.busy === 1'b1) busy_seen++;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dbz_done_pulse got=%b exp=0", bus.done); end
      checks++; if (bus.div_by_zero !== 1'b1 || bus.remainder !== 64'd1228) begin failures++; $display("FAIL dbz_hold dbz=%b rem=%0d exp=1/1228", bus.div_by_zero, bus.remainder); end
      tick();
      if (bus.busy === 1'b1) busy_seen++;
      checks++; if (busy_seen !== 0) begin failures++; $display("FAIL dbz_busy got=%0d busy cycles exp=0", busy_seen); end
   endtask

   task automatic test_divide();
      string        names [5] = '{"div_100_7", "div_25623210_222340", "div_max_1", "div_5_large", "div_max_large"};
      logic [W-1:0] va    [5] = '{64'd100, 64'd25623210, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [W-1:0] vb    [5] = '{64'd7, 64'd222340, 64'd1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
      logic [W-1:0] vq    [5] = '{64'd14, 64'd115, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
      logic [W-1:0] vr    [5] = '{64'd2, 64'd54110, 64'd0, 64'd5, 64'h7FFF_FFFF_FFFF_FFFE};
      int lat;
      int busy_cycles;
      for (int i = 0; i < 5; i++) begin
         launch(va[i], vb[i]);
         wait_done(lat, busy_cycles);
         checks++; if (lat !== W) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", names[i], lat, W); end
         checks++; if (busy_cycles !== W) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", names[i], busy_cycles, W); end
         checks++; if (bus.quotient !== vq[i]) begin failures++; $display("FAIL %s quotient got=%h exp=%h", names[i], bus.quotient, vq[i]); end
         checks++; if (bus.remainder !== vr[i]) begin failures++; $display("FAIL %s remainder got=%h exp=%h", names[i], bus.remainder, vr[i]); end
         checks++; if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL %s status dbz=%b busy=%b exp=0/0", names[i], bus.div_by_zero, bus.busy); end
         tick();
         checks++; if (bus.done !== 1'b0 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin failures++; $display("FAIL %s hold done=%b q=%h r=%h exp done=0 q=%h r=%h", names[i], bus.done, bus.quotient, bus.remainder, vq[i], vr[i]); end
      end
   endtask

   task automatic test_ignore_and_reset();
      int lat;
      int busy_cycles;
      int done_seen;
      launch(64'd1000, 64'd3);
      for (int i = 1; i < 10; i++) tick();
      bus.dividend = 64'd9;
      bus.divisor  = 64'd9;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignored_start_busy got=%b exp=1", bus.busy); end
      for (int i = 11; i < 30; i++) tick();
      rst = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midrun_reset busy=%b done=%b exp=0/0", bus.busy, bus.done); end
      checks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL midrun_reset_outputs q=%h r=%h dbz=%b exp=0/0/0", bus.quotient, bus.remainder, bus.div_by_zero); end
      tick();
      rst       = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
         tick();
      end
      checks++; if (done_seen !== 0) begin failures++; $display("FAIL reset_discards_run got=%0d active cycles exp=0", done_seen); end
      launch(64'd9, 64'd9);
      wait_done(lat, busy_cycles);
      checks++; if (lat !== W) begin failures++; $display("FAIL div_9_9 latency got=%0d exp=%0d", lat, W); end
      checks++; if (bus.quotient !== 64'd1 || bus.remainder !== 64'd0) begin failures++; $display("FAIL div_9_9 q=%0d r=%0d exp=1/0", bus.quotient, bus.remainder); end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      int busy_cycles;
      launch(64'd20, 64'd20);
      wait_done(lat, busy_cycles);
      checks++; if (lat !== W) begin failures++; $display("FAIL b2b_first latency got=%0d exp=%0d", lat, W); end
      checks++; if (bus.quotient !== 64'd1 || bus.remainder !== 64'd0) begin failures++; $display("FAIL b2b_first q=%0d r=%0d exp=1/0", bus.quotient, bus.remainder); end
      launch(64'd75, 64'd8);
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", bus.busy, bus.done); end
      wait_done(lat, busy_cycles);
      checks++; if (lat !== W || busy_cycles !== W) begin failures++; $display("FAIL b2b_second latency=%0d busy=%0d exp=%0d/%0d", lat, busy_cycles, W, W); end
      checks++; if (bus.quotient !== 64'd9 || bus.remainder !== 64'd3) begin failures++; $display("FAIL b2b_second q=%0d r=%0d exp=9/3", bus.quotient, bus.remainder); end
      tick();
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle done=%b busy=%b exp=0/0", bus.done, bus.busy); end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      test_reset();
      test_div_by_zero();
      test_divide();
      test_ignore_and_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_divider_64.md
# seq_divider_64

Iterative unsigned restoring divider that performs the inverse operation to the block carry-select multiply/add datapath. It accepts a 64-bit dividend and divisor on a start pulse and produces quotient and remainder one bit per clock. The carry-select subtractor is reused as its trial-subtract stage. It is the divide engine next to the 8-block adder/multiplier in the arithmetic unit and shares its clk/rst domain.

## Interface
- WIDTH, 64, operand/result width in bits; must be a multiple of 8 (8-bit CSA blocks).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  unsigned numerator, captured on an accepted start.
- divisor  input  WIDTH  unsigned denominator, captured on an accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result; held stable until the next accepted start.
- remainder  output  WIDTH  result; held stable until the next accepted start.
- div_by_zero  output  1  set with done when divisor == 0; held with the results.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=0, RUN=1, DONE=2.
- IDLE or DONE, start=1, divisor!=0:
  - Capture operands: Q := dividend, R := 0, D := divisor, count := 0.
  - Go to RUN.
- IDLE or DONE, start=1, divisor==0:
  - quotient := all ones, remainder := dividend, div_by_zero := 1.
  - Go to DONE.
- RUN, each cycle (restoring step):
  - T := {R[WIDTH-2:0], Q[WIDTH-1]}.
  - Compute T - D on the CSA subtractor with borrow out.
  - If no borrow: R := T - D and Q := {Q[WIDTH-2:0], 1}.
  - Otherwise: R := T and Q := {Q[WIDTH-2:0], 0}.
  - count increments. When count == WIDTH-1, this is the final step: go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE, unless a new start is accepted in that same cycle.
- start is ignored in RUN. There is no queuing and no abort.
- div_by_zero clears on the next accepted start.
- Width rule: internal R is WIDTH bits. Using a WIDTH+1-bit trial value (T concatenated with the shifted-out R MSB) is required so that no overflow occurs when D > 2^(WIDTH-1).

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset wins over every other event in the same cycle, including mid-RUN. All operation state is discarded.
- Normal latency:
  - start is sampled at edge k.
  - busy is high during cycles k+1 through k+WIDTH.
  - done is high during the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance (64 by default).
  - quotient and remainder are valid from that same cycle.
- Divide-by-zero latency: done is high in the cycle after the accepting edge (1 cycle). busy stays 0.
- Back-to-back: a start in the DONE cycle is accepted, so the next busy follows immediately.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package arith_pkg:
  - DIV_WIDTH = 64.
  - State type div_state_t with IDLE/RUN/DONE.
  - CSA_BLOCK = 8.
- Sub-module block_csa_sub:
  - WIDTH-bit subtractor built from WIDTH/8 carry-select blocks.
  - Inputs a, b; outputs diff and borrow_out.
  - Implemented as a + ~b with cin=1, reusing the existing adder block style.
- Top level holds the FSM, the counter, and the Q/R/D registers.

## Test plan
- 100 / 7 -> done after 64 cycles; quotient=14, remainder=2, div_by_zero=0, busy high for exactly 64 cycles.
- 25623210 / 222340 -> quotient=115, remainder=54110.
- 1228 / 0 -> done one cycle after start; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=1228, div_by_zero=1, busy never high.
- 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0. Also 5 / 0x8000_0000_0000_0001 -> quotient=0, remainder=5 (checks the large-divisor case).
- Start 1000 / 3. Pulse start with 9 / 9 at cycle 10, which must be ignored. Assert rst at cycle 30, which must force busy=0 and zero all outputs with no done. Then 9 / 9 -> quotient=1, remainder=0.
- Back-to-back: start 20 / 20 then, in its DONE cycle, start 75 / 8 -> first result quotient=1, remainder=0; second done 64 cycles later with quotient=9, remainder=3.
